seq_detector_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector. Generalises the fixed-pattern 5-bit detector to any pattern of 1..MAX_LEN bits.
- Adds selectable overlap or non-overlap mode, an input valid qualifier, a registered detect pulse and a saturating detection counter.
- Sits on a serial data path after the deserialiser/sampler and flags frame markers for downstream control logic.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_detector_prog_sat_counter.sv | 24 ++
 rtl/seq_detector_prog.sv | 107 ++++++++++
 tb/tb_seq_detector_prog.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Width that can hold any length 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CMAX = WIDTH'(sat_max(WIDTH));

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_count <= '0;
    else if (inc && (r_count != CMAX)) r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// valid qualifier, registered detect pulse and saturating detect counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   det_count,
  output logic               cfg_err,
  output logic               running
);

  state_e               r_state, w_state_nxt;
  logic [MAX_LEN-1:0]   r_hist, r_pat;
  logic [LEN_W-1:0]     r_fill, r_len;
  logic                 r_ovl, r_det, r_err;

  logic                 w_cfg_ok, w_beat, w_match;
  logic [MAX_LEN-1:0]   w_hist_nxt, w_mask;
  logic [MAX_LEN:0]     w_mask_ext;
  logic [LEN_W:0]       w_fill_inc;
  logic [LEN_W-1:0]     w_fill_sat;

  assign w_cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // A load in the same cycle as a valid beat wins; that beat is dropped.
  assign w_beat     = (r_state == RUN) && in_valid && !cfg_load;
  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], in_data};

  // One extra bit so len == MAX_LEN yields an all-ones mask.
  assign w_mask_ext = ((MAX_LEN+1)'(1) << r_len) - (MAX_LEN+1)'(1);
  assign w_mask     = w_mask_ext[MAX_LEN-1:0];

  assign w_fill_inc = (LEN_W+1)'(r_fill) + (LEN_W+1)'(1);
  assign w_fill_sat = (w_fill_inc > (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                         : w_fill_inc[LEN_W-1:0];

  assign w_match = w_beat
                && (((w_hist_nxt ^ r_pat) & w_mask) == '0)
                && (w_fill_inc >= (LEN_W+1)'(r_len));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cfg_load) w_state_nxt = w_cfg_ok ? RUN : IDLE;
  end

  always_comb begin
    running = (r_state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= '0;
      r_len  <= '0;
      r_ovl  <= 1'b0;
      r_det  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_det <= w_match;
      if (cfg_load) begin
        if (w_cfg_ok) begin
          r_pat <= cfg_pattern;
          r_len <= cfg_len;
          r_ovl <= cfg_overlap;
          r_err <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
        r_hist <= '0;
        r_fill <= '0;
      end else if (w_beat) begin
        r_hist <= w_hist_nxt;
        // Non-overlap: the next match must be built from fresh bits.
        r_fill <= (w_match && !r_ovl) ? '0 : w_fill_sat;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_match),
    .count (det_count)
  );

  assign det_pulse = r_det;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench: directed table, hand corner sequences and random traffic against a
// bit-queue reference model; a second instance with CNT_W=2 covers saturation.
module tb_seq_detector_prog;

  localparam int ML = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_load, cfg_overlap, in_valid, in_data;
  logic [ML-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          det_pulse, cfg_err, running;
  logic [15:0]   det_count;
  logic          det_pulse2, cfg_err2, running2;
  logic [1:0]    det_count2;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(ML), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_data(in_data), .det_pulse(det_pulse), .det_count(det_count),
    .cfg_err(cfg_err), .running(running));

  seq_detector_prog #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_data(in_data), .det_pulse(det_pulse2), .det_count(det_count2),
    .cfg_err(cfg_err2), .running(running2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the valid bits seen since the last restart, newest last.
  bit            m_run, m_err, m_ovl, m_pulse;
  bit [ML-1:0]   m_pat;
  int            m_len;
  int            m_cnt, m_cnt2;
  bit            bits[$];

  task automatic model_reset();
    m_run = 0; m_err = 0; m_ovl = 0; m_pulse = 0; m_pat = '0; m_len = 0;
    m_cnt = 0; m_cnt2 = 0; bits.delete();
  endtask

  task automatic model_edge(input bit ld, input bit [ML-1:0] pat, input int len,
                            input bit ovl, input bit v, input bit d);
    bit hit;
    hit = 0;
    if (ld) begin
      if (len >= 1 && len <= ML) begin
        m_run = 1; m_err = 0; m_pat = pat; m_len = len; m_ovl = ovl;
      end else begin
        m_run = 0; m_err = 1;
      end
      bits.delete();
    end else if (m_run && v) begin
      bits.push_back(d);
      if (bits.size() > ML) void'(bits.pop_front());
      if (bits.size() >= m_len) begin
        hit = 1;
        for (int j = 0; j < m_len; j++)
          if (bits[bits.size()-1-j] != m_pat[j]) hit = 0;
      end
      if (hit) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!m_ovl) bits.delete();
      end
    end
    m_pulse = hit;
  endtask

  task automatic step(input bit ld, input bit [ML-1:0] pat, input int len,
                      input bit ovl, input bit v, input bit d);
    cfg_load = ld; cfg_pattern = pat; cfg_len = LW'(len); cfg_overlap = ovl;
    in_valid = v; in_data = d;
    model_edge(ld, pat, len, ovl, v, d);
    @(posedge clk);
    #1;
    chk("pulse",   det_pulse,  m_pulse);
    chk("count",   det_count,  m_cnt);
    chk("running", running,    m_run);
    chk("cfg_err", cfg_err,    m_err);
    chk("pulse2",  det_pulse2, m_pulse);
    chk("count2",  det_count2, m_cnt2);
  endtask

  typedef struct {
    bit          ld;
    bit [ML-1:0] pat;
    int          len;
    bit          ovl;
    bit          v;
    bit          d;
    bit          ep;
    int          ec;
    bit          er;
    bit          ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit ld, bit [ML-1:0] pat, int len, bit ovl, bit v,
                              bit d, bit ep, int ec, bit er, bit ee);
    vec_t x;
    x.ld = ld; x.pat = pat; x.len = len; x.ovl = ovl; x.v = v; x.d = d;
    x.ep = ep; x.ec = ec; x.er = er; x.ee = ee;
    return x;
  endfunction

  task automatic bit_row(input bit d, input bit ep, input int ec);
    tbl.push_back(mk(0, '0, 0, 0, 1, d, ep, ec, 1, 0));
  endtask

  initial begin
    bit [ML-1:0] p10110;
    p10110 = 8'b0001_0110;
    model_reset();
    rst_n = 1'b0; cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 0; in_valid = 0; in_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulse", det_pulse, 0);
    chk("rst_count", det_count, 0);
    chk("rst_running", running, 0);
    chk("rst_err", cfg_err, 0);
    rst_n = 1'b1;

    // Overlap on: 1,0,1,1,0,1,1,0 -> hits at bits 5 and 8
    tbl.push_back(mk(1, p10110, 5, 1, 0, 0, 0, 0, 1, 0));
    bit_row(1,0,0); bit_row(0,0,0); bit_row(1,0,0); bit_row(1,0,0);
    bit_row(0,1,1); bit_row(1,0,1); bit_row(1,0,1); bit_row(0,1,2);
    tbl.push_back(mk(0, '0, 0, 0, 0, 0, 0, 2, 1, 0));
    // Overlap off: only bit 5 hits
    tbl.push_back(mk(1, p10110, 5, 0, 0, 0, 0, 2, 1, 0));
    bit_row(1,0,2); bit_row(0,0,2); bit_row(1,0,2); bit_row(1,0,2);
    bit_row(0,1,3); bit_row(1,0,3); bit_row(1,0,3); bit_row(0,0,3);
    // len=1: back-to-back pulses
    tbl.push_back(mk(1, 8'b1, 1, 1, 0, 0, 0, 3, 1, 0));
    bit_row(1,1,4); bit_row(1,1,5); bit_row(0,0,5); bit_row(1,1,6);
    // Illegal length, then a legal reload
    tbl.push_back(mk(1, 8'b101, 0, 1, 0, 0, 0, 6, 0, 1));
    tbl.push_back(mk(0, '0, 0, 0, 1, 1, 0, 6, 0, 1));
    tbl.push_back(mk(1, 8'b101, 3, 1, 0, 0, 0, 6, 1, 0));
    // Load collides with the completing beat: beat dropped
    tbl.push_back(mk(1, p10110, 5, 1, 0, 0, 0, 6, 1, 0));
    bit_row(1,0,6); bit_row(0,0,6); bit_row(1,0,6); bit_row(1,0,6);
    tbl.push_back(mk(1, p10110, 5, 1, 1, 0, 0, 6, 1, 0));
    tbl.push_back(mk(0, '0, 0, 0, 0, 0, 0, 6, 1, 0));
    bit_row(0,0,6);

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_pulse", i),   det_pulse, tbl[i].ep);
      chk($sformatf("tbl%0d_count", i),   det_count, tbl[i].ec);
      chk($sformatf("tbl%0d_running", i), running,   tbl[i].er);
      chk($sformatf("tbl%0d_err", i),     cfg_err,   tbl[i].ee);
    end

    // Gapped stream: idle beats carry junk data that must be ignored
    step(1, p10110, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bit b;
      b = p10110[4-i];
      step(0, '0, 0, 0, 1, b);
      chk("gap_pulse", det_pulse, (i == 4));
      step(0, '0, 0, 0, 0, ~b);
      chk("gap_idle", det_pulse, 0);
    end
    chk("gap_count", det_count, 7);

    // Async reset while a pulse is high
    step(1, 8'b1, 1, 1, 0, 0);
    step(0, '0, 0, 0, 1, 1);
    chk("pre_rst_pulse", det_pulse, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pulse", det_pulse, 0);
    chk("arst_count", det_count, 0);
    chk("arst_running", running, 0);
    chk("arst_err", cfg_err, 0);
    chk("arst_count2", det_count2, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) step(0, '0, 0, 0, 1, 1);

    // Saturation of the narrow counter
    step(1, 8'b1, 1, 1, 0, 0);
    repeat (5) step(0, '0, 0, 0, 1, 1);
    chk("sat_count2", det_count2, 3);
    chk("sat_count16", det_count, 5);
    step(0, '0, 0, 0, 1, 1);
    chk("sat_hold2", det_count2, 3);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit ld;
      ld = ($urandom_range(0, 39) == 0);
      step(ld, ML'($urandom), $urandom_range(0, ML + 1), $urandom_range(0, 1),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
